// File: rtl/dualram_arb_pkg.sv
// Shared types and default sizes for the dualram write arbiter.
package dualram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned DEPTH_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    RESP    = 3'd3,
    ERR     = 3'd4
  } arb_state_e;

  typedef logic client_id_t;

endpackage

// File: rtl/dualram_arbiter_if.sv
// One client's write request / response channel into the dualram arbiter.
interface dualram_arbiter_if
  import dualram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; last_gnt advances only when a grant is accepted.
module rr_arb2
  import dualram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output client_id_t gnt_id
);

  client_id_t last_gnt;

  // A lone requester always wins; a tie goes to the client not served last.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == 1'b1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign gnt_id = gnt[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (accept) begin
      last_gnt <= gnt_id;
    end
  end

endmodule

// File: rtl/dualram_arbiter.sv
// Round-robin write sequencer for two clients in front of the dualram 8x4 RAM:
// one transaction every four cycles, echo returned as a one-cycle response.
module dualram_arbiter
  import dualram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  dualram_arbiter_if.slave  cl0,
  dualram_arbiter_if.slave  cl1,
  output logic              ram_wr_en,
  output logic              ram_port_0,
  output logic              ram_port_1,
  output logic [ADDR_W-1:0] ram_addr_0,
  output logic [ADDR_W-1:0] ram_addr_1,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  arb_state_e state, state_n;

  logic [1:0]        req;
  logic [1:0]        gnt;
  client_id_t        gnt_id;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  client_id_t        client_q, client_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] data_q, data_n;

  logic              ram_wr_en_n, ram_port_0_n, ram_port_1_n;
  logic [ADDR_W-1:0] ram_addr_0_n, ram_addr_1_n;
  logic [DATA_W-1:0] ram_data_in_n;

  logic [1:0]             rsp_valid_q, rsp_valid_n;
  logic [1:0]             rsp_err_q, rsp_err_n;
  logic [1:0][DATA_W-1:0] rsp_data_q, rsp_data_n;

  assign req      = {cl1.req_valid, cl0.req_valid};
  assign accept   = (state == IDLE) && (|req);
  assign sel_addr = gnt[1] ? cl1.req_addr : cl0.req_addr;
  assign sel_data = gnt[1] ? cl1.req_data : cl0.req_data;

  assign cl0.req_ready = (state == IDLE) && gnt[0];
  assign cl1.req_ready = (state == IDLE) && gnt[1];

  rr_arb2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (accept),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state plus next value of every registered output, so outputs line up with state.
  always_comb begin
    state_n  = state;
    client_n = client_q;
    addr_n   = addr_q;
    data_n   = data_q;

    case (state)
      IDLE: begin
        if (accept) begin
          client_n = gnt_id;
          addr_n   = sel_addr;
          data_n   = sel_data;
          state_n  = ({1'b0, sel_addr} < DEPTH_L) ? ISSUE : ERR;
        end
      end
      ISSUE:   state_n = CAPTURE;
      CAPTURE: state_n = RESP;
      RESP:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    ram_wr_en_n   = (state_n == ISSUE);
    ram_port_0_n  = ram_wr_en_n && (client_n == 1'b0);
    ram_port_1_n  = ram_wr_en_n && (client_n == 1'b1);
    ram_addr_0_n  = ram_port_0_n ? addr_n : '0;
    ram_addr_1_n  = ram_port_1_n ? addr_n : '0;
    ram_data_in_n = ram_wr_en_n ? data_n : '0;

    // Response data/err hold between pulses; only the served client's copy changes.
    rsp_valid_n = 2'b00;
    rsp_err_n   = rsp_err_q;
    rsp_data_n  = rsp_data_q;
    if (state_n == RESP) begin
      rsp_valid_n[client_n] = 1'b1;
      rsp_err_n[client_n]   = 1'b0;
      rsp_data_n[client_n]  = ram_out;
    end else if (state_n == ERR) begin
      rsp_valid_n[client_n] = 1'b1;
      rsp_err_n[client_n]   = 1'b1;
      rsp_data_n[client_n]  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      client_q    <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      ram_wr_en   <= 1'b0;
      ram_port_0  <= 1'b0;
      ram_port_1  <= 1'b0;
      ram_addr_0  <= '0;
      ram_addr_1  <= '0;
      ram_data_in <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_data_q  <= '0;
      busy        <= 1'b0;
    end else begin
      client_q    <= client_n;
      addr_q      <= addr_n;
      data_q      <= data_n;
      ram_wr_en   <= ram_wr_en_n;
      ram_port_0  <= ram_port_0_n;
      ram_port_1  <= ram_port_1_n;
      ram_addr_0  <= ram_addr_0_n;
      ram_addr_1  <= ram_addr_1_n;
      ram_data_in <= ram_data_in_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_err_q   <= rsp_err_n;
      rsp_data_q  <= rsp_data_n;
      busy        <= (state_n != IDLE);
    end
  end

  assign cl0.rsp_valid = rsp_valid_q[0];
  assign cl0.rsp_err   = rsp_err_q[0];
  assign cl0.rsp_data  = rsp_data_q[0];
  assign cl1.rsp_valid = rsp_valid_q[1];
  assign cl1.rsp_err   = rsp_err_q[1];
  assign cl1.rsp_data  = rsp_data_q[1];

  a_port_excl: assert property (@(posedge clk) !(ram_port_0 && ram_port_1));

endmodule

// File: tb/tb_dualram_arbiter.sv
// Directed bench for dualram_arbiter: cycle-by-cycle vector table plus
// hand-written fairness, reset-in-flight and lone-requester sequences.
module tb_dualram_arbiter;
  import dualram_arb_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned DP = 8;
  localparam int NV = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dualram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cl0 ();
  dualram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cl1 ();

  logic          ram_wr_en, ram_port_0, ram_port_1, busy;
  logic [AW-1:0] ram_addr_0, ram_addr_1;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_out = '0;

  dualram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cl0         (cl0),
    .cl1         (cl1),
    .ram_wr_en   (ram_wr_en),
    .ram_port_0  (ram_port_0),
    .ram_port_1  (ram_port_1),
    .ram_addr_0  (ram_addr_0),
    .ram_addr_1  (ram_addr_1),
    .ram_data_in (ram_data_in),
    .ram_out     (ram_out),
    .busy        (busy)
  );

  // RAM stand-in: echoes the written word on out after the write edge.
  always @(posedge clk) begin
    if (ram_wr_en && (ram_port_0 || ram_port_1)) ram_out <= ram_data_in;
  end

  typedef struct packed {
    logic rst; logic v0; logic [3:0] a0; logic [3:0] d0;
    logic v1; logic [3:0] a1; logic [3:0] d1;
  } in_t;

  typedef struct packed {
    logic busy; logic rdy0; logic rdy1; logic wr; logic p0; logic p1;
    logic [3:0] a0; logic [3:0] a1; logic [3:0] din;
    logic rv0; logic [3:0] rd0; logic re0;
    logic rv1; logic [3:0] rd1; logic re1;
  } out_t;

  typedef struct { in_t i; out_t o; } vec_t;

  vec_t vecs [NV];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic in_t mk_i(int r, int v0, int a0, int d0, int v1, int a1, int d1);
    in_t x;
    x = '{rst: 1'(r), v0: 1'(v0), a0: 4'(a0), d0: 4'(d0), v1: 1'(v1), a1: 4'(a1), d1: 4'(d1)};
    return x;
  endfunction

  function automatic out_t mk_o(int b, int r0, int r1, int w, int p0, int p1,
                                int a0, int a1, int din, int rv0, int rd0, int re0,
                                int rv1, int rd1, int re1);
    out_t x;
    x = '{busy: 1'(b), rdy0: 1'(r0), rdy1: 1'(r1), wr: 1'(w), p0: 1'(p0), p1: 1'(p1),
          a0: 4'(a0), a1: 4'(a1), din: 4'(din), rv0: 1'(rv0), rd0: 4'(rd0), re0: 1'(re0),
          rv1: 1'(rv1), rd1: 4'(rd1), re1: 1'(re1)};
    return x;
  endfunction

  function automatic out_t sample();
    out_t x;
    x = '{busy: busy, rdy0: cl0.req_ready, rdy1: cl1.req_ready, wr: ram_wr_en,
          p0: ram_port_0, p1: ram_port_1, a0: ram_addr_0, a1: ram_addr_1, din: ram_data_in,
          rv0: cl0.rsp_valid, rd0: cl0.rsp_data, re0: cl0.rsp_err,
          rv1: cl1.rsp_valid, rd1: cl1.rsp_data, re1: cl1.rsp_err};
    return x;
  endfunction

  task automatic drive(input in_t x);
    rst_n         = x.rst;
    cl0.req_valid = x.v0;
    cl0.req_addr  = x.a0;
    cl0.req_data  = x.d0;
    cl1.req_valid = x.v1;
    cl1.req_addr  = x.a1;
    cl1.req_data  = x.d1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, r0c, r1c, ng, last_c, p0_seen, rv_seen;
    logic acc0, acc1;

    // Rows: single write to 3, out-of-range 9 from client 1, then contention 0 vs 1.
    vecs[0]  = '{mk_i(0,0,0,0,0,0,0),  mk_o(0,0,0,0,0,0, 0,0,0,   0,0,0,  0,0,0)};
    vecs[1]  = '{mk_i(1,1,3,10,0,0,0), mk_o(0,1,0,0,0,0, 0,0,0,   0,0,0,  0,0,0)};
    vecs[2]  = '{mk_i(1,0,0,0,0,0,0),  mk_o(1,0,0,1,1,0, 3,0,10,  0,0,0,  0,0,0)};
    vecs[3]  = '{mk_i(1,0,0,0,0,0,0),  mk_o(1,0,0,0,0,0, 0,0,0,   0,0,0,  0,0,0)};
    vecs[4]  = '{mk_i(1,0,0,0,0,0,0),  mk_o(1,0,0,0,0,0, 0,0,0,   1,10,0, 0,0,0)};
    vecs[5]  = '{mk_i(1,0,0,0,1,9,3),  mk_o(0,0,1,0,0,0, 0,0,0,   0,10,0, 0,0,0)};
    vecs[6]  = '{mk_i(1,0,0,0,0,0,0),  mk_o(1,0,0,0,0,0, 0,0,0,   0,10,0, 1,0,1)};
    vecs[7]  = '{mk_i(1,1,1,5,1,2,9),  mk_o(0,1,0,0,0,0, 0,0,0,   0,10,0, 0,0,1)};
    vecs[8]  = '{mk_i(1,0,0,0,1,2,9),  mk_o(1,0,0,1,1,0, 1,0,5,   0,10,0, 0,0,1)};
    vecs[9]  = '{mk_i(1,0,0,0,1,2,9),  mk_o(1,0,0,0,0,0, 0,0,0,   0,10,0, 0,0,1)};
    vecs[10] = '{mk_i(1,0,0,0,1,2,9),  mk_o(1,0,0,0,0,0, 0,0,0,   1,5,0,  0,0,1)};
    vecs[11] = '{mk_i(1,0,0,0,1,2,9),  mk_o(0,0,1,0,0,0, 0,0,0,   0,5,0,  0,0,1)};
    vecs[12] = '{mk_i(1,0,0,0,0,0,0),  mk_o(1,0,0,1,0,1, 0,2,9,   0,5,0,  0,0,1)};
    vecs[13] = '{mk_i(1,0,0,0,0,0,0),  mk_o(1,0,0,0,0,0, 0,0,0,   0,5,0,  0,0,1)};
    vecs[14] = '{mk_i(1,0,0,0,0,0,0),  mk_o(1,0,0,0,0,0, 0,0,0,   0,5,0,  1,9,0)};
    vecs[15] = '{mk_i(1,0,0,0,0,0,0),  mk_o(0,0,0,0,0,0, 0,0,0,   0,5,0,  0,9,0)};

    drive(mk_i(0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(vecs[k].i);
      #1;
      chk($sformatf("vec%0d", k), 32'(sample()), 32'(vecs[k].o));
    end

    // Fairness: both clients always requesting, 8 grants alternating from client 0.
    @(negedge clk);
    drive(mk_i(0,0,0,0,0,0,0));
    @(negedge clk);
    @(negedge clk);
    drive(mk_i(1,1,0,1,1,0,8));
    n0 = 0; n1 = 0; r0c = 0; r1c = 0; ng = 0; last_c = 0; acc0 = 0; acc1 = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (cl0.rsp_valid) begin
        chk("fair_rsp0_data", 32'(cl0.rsp_data), 32'(r0c + 1));
        r0c++;
      end
      if (cl1.rsp_valid) begin
        chk("fair_rsp1_data", 32'(cl1.rsp_data), 32'(r1c + 8));
        r1c++;
      end
      if (ng < 8 && ((cl0.req_valid && cl0.req_ready) || (cl1.req_valid && cl1.req_ready))) begin
        chk("fair_order", 32'(cl1.req_ready), 32'(ng % 2));
        if (ng > 0) chk("fair_spacing", 32'(c - last_c), 32'(4));
        last_c = c;
        ng++;
        acc0 = cl0.req_ready;
        acc1 = cl1.req_ready;
      end
      @(negedge clk);
      if (acc0) begin n0++; cl0.req_addr = 4'(n0); cl0.req_data = 4'(n0 + 1); acc0 = 0; end
      if (acc1) begin n1++; cl1.req_addr = 4'(n1); cl1.req_data = 4'(n1 + 8); acc1 = 0; end
      if (ng >= 8) begin cl0.req_valid = 1'b0; cl1.req_valid = 1'b0; end
    end
    chk("fair_grants", 32'(ng), 32'(8));
    chk("fair_rsp0_count", 32'(r0c), 32'(4));
    chk("fair_rsp1_count", 32'(r1c), 32'(4));

    // Reset asserted during CAPTURE drops the response; next write completes normally.
    drive(mk_i(0,0,0,0,0,0,0));
    @(negedge clk);
    @(negedge clk);
    drive(mk_i(1,1,5,7,0,0,0));
    #1 chk("rst_ready0", 32'(cl0.req_ready), 32'(1));
    @(negedge clk);
    cl0.req_valid = 1'b0;
    #1 chk("rst_issue_wr", 32'(ram_wr_en), 32'(1));
    @(negedge clk);
    #1 chk("rst_capture_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_outputs_zero", 32'(sample()), 32'(0));
    rv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 if (cl0.rsp_valid || busy) rv_seen++;
    end
    chk("rst_no_rsp", 32'(rv_seen), 32'(0));
    drive(mk_i(1,1,0,15,0,0,0));
    #1 chk("rst_next_ready0", 32'(cl0.req_ready), 32'(1));
    @(negedge clk);
    cl0.req_valid = 1'b0;
    #1 chk("rst_next_issue", 32'({ram_wr_en, ram_port_0, ram_port_1, ram_addr_0, ram_data_in}),
           32'({1'b1, 1'b1, 1'b0, 4'h0, 4'hF}));
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_next_rsp", 32'({cl0.rsp_valid, cl0.rsp_data, cl0.rsp_err}),
           32'({1'b1, 4'hF, 1'b0}));

    // Lone requester: client 1 granted three times in a row, port 0 never touched.
    @(negedge clk);
    drive(mk_i(1,0,0,0,1,4,3));
    n1 = 0; r1c = 0; p0_seen = 0; acc1 = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ram_port_0) p0_seen++;
      if (cl1.rsp_valid) begin
        chk("lone_rsp1", 32'({cl1.rsp_data, cl1.rsp_err}), 32'({4'(r1c + 3), 1'b0}));
        r1c++;
      end
      if (cl1.req_valid && cl1.req_ready) acc1 = 1'b1;
      @(negedge clk);
      if (acc1) begin
        n1++;
        cl1.req_addr = 4'(n1 + 4);
        cl1.req_data = 4'(n1 + 3);
        acc1 = 1'b0;
        if (n1 >= 3) cl1.req_valid = 1'b0;
      end
    end
    chk("lone_grants", 32'(n1), 32'(3));
    chk("lone_rsp_count", 32'(r1c), 32'(3));
    chk("lone_port0_idle", 32'(p0_seen), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dualram_arbiter.md
Name: dualram_arbiter

Overview:
- Two-requester write arbiter and sequencer in front of the `dualram` 8x4 RAM.
- Accepts write requests from two clients over valid/ready and grants one at a time, round-robin.
- Drives the RAM's `wr_en`/`port_0`/`port_1`/address/data pins for exactly one cycle per transaction.
- Captures the RAM's `out` echo and returns it to the winning client as a one-cycle response, or returns an error for out-of-range addresses.

Parameters:
- ADDR_W, 4, address width of RAM and request ports.
- DATA_W, 4, data width.
- DEPTH, 8, number of valid RAM words; addresses >= DEPTH are rejected.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  client 0 write request.
- req0_ready  out  1  client 0 request accepted this cycle.
- req0_addr  in  ADDR_W  client 0 write address.
- req0_data  in  DATA_W  client 0 write data.
- rsp0_valid  out  1  one-cycle response pulse to client 0.
- rsp0_data  out  DATA_W  RAM echo value for client 0.
- rsp0_err  out  1  client 0 address out of range.
- req1_valid, req1_ready, req1_addr, req1_data, rsp1_valid, rsp1_data, rsp1_err: identical set for client 1.
- ram_wr_en  out  1  to RAM `wr_en`.
- ram_port_0  out  1  to RAM `port_0`; client 0 traffic only.
- ram_port_1  out  1  to RAM `port_1`; client 1 traffic only.
- ram_addr_0  out  ADDR_W  to RAM `addr_0`.
- ram_addr_1  out  ADDR_W  to RAM `addr_1`.
- ram_data_in  out  DATA_W  to RAM `data_in`.
- ram_out  in  DATA_W  from RAM `out`.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - `last_gnt` = 1, so client 0 wins the first tie.
  - Captured address/data/client registers 0.
- FSM states: IDLE, ISSUE, CAPTURE, RESP, ERR.
- IDLE:
  - `reqN_ready` is combinational: (state==IDLE) && gnt_N.
  - With one valid, grant it.
  - With both valid, grant the client != `last_gnt`.
  - On accept (valid && ready): latch addr, data and client id; update `last_gnt`.
  - Go to ISSUE if addr < DEPTH, else to ERR.
- ISSUE (1 cycle, registered outputs):
  - `ram_wr_en`=1.
  - Exactly one of `ram_port_0`/`ram_port_1`=1, per client.
  - That port's `ram_addr_N` = latched addr; the other address = 0.
  - `ram_data_in` = latched data.
  - RAM writes at the end of this cycle.
  - Go to CAPTURE.
- CAPTURE:
  - All `ram_*` outputs return to 0.
  - Sample `ram_out` into a response register.
  - Go to RESP.
- RESP:
  - `rspN_valid`=1 for exactly one cycle to the latched client.
  - `rspN_data` = captured value; `rspN_err`=0.
  - Go to IDLE.
- ERR:
  - `rspN_valid`=1 and `rspN_err`=1 for one cycle.
  - `rspN_data`=0; no RAM pins asserted.
  - Go to IDLE.
- Latency:
  - Accept edge T, RAM write at T+1, `rsp_valid` at T+3.
  - Next accept at T+4, giving a throughput of 1 write per 4 cycles.
  - Error response at T+1.
- `rsp*_data`/`rsp*_err` hold their value outside the valid pulse; consumers qualify with valid.
- No backpressure on responses; clients must accept the rsp pulse.
- A request held valid while not ready must keep addr/data stable; it is served in a later IDLE.
- Simultaneous requests strictly alternate; a lone requester is granted every IDLE regardless of `last_gnt`.
- Reset mid-transaction (any state):
  - Next edge returns to IDLE with all outputs 0.
  - The in-flight response is dropped.
  - A write already performed in ISSUE is not undone.
- Address wrap: none. addr == DEPTH..2^ADDR_W-1 always goes to ERR.
- `ram_port_0` and `ram_port_1` are never both 1 (assertion required).

Decomposition:
- Package `dualram_arb_pkg`:
  - State enum `arb_state_e` {IDLE, ISSUE, CAPTURE, RESP, ERR}.
  - Localparams for default ADDR_W/DATA_W/DEPTH.
  - Client-id typedef (1 bit).
- Sub-module `rr_arb2`: 2-way round-robin grant from req[1:0] and `last_gnt`; combinational grant plus `last_gnt` register updated on accept.

Test Plan:
- Single write: reset, req0 addr=3 data=0xA -> `req0_ready` at T; `ram_wr_en`=1, `ram_port_0`=1, `ram_addr_0`=3 at T+1; `rsp0_valid`=1, `rsp0_data`=0xA, `rsp0_err`=0 at T+3.
- Contention: req0 (addr=1, data=0x5) and req1 (addr=2, data=0x9) held valid from reset -> client 0 served first (`rsp0_data`=0x5), then client 1 (`ram_port_1`=1, `ram_addr_1`=2, `rsp1_data`=0x9); the 4-cycle spacing holds.
- Fairness: both valid continuously for 8 transactions -> grants alternate 0,1,0,1,...; each client gets 4 rsp pulses.
- Out of range: req1 addr=9 data=0x3 -> `rsp1_valid`=1, `rsp1_err`=1 at T+1; `ram_wr_en` never asserted.
- Reset mid-operation: drop `rst_n` during CAPTURE of a req0 write -> no `rsp0_valid`, `busy`=0 and all `ram_*`=0 after the edge; next req0 addr=0 data=0xF completes normally.
- Lone requester after a grant: req1 only, 3 back-to-back writes -> all granted; `ram_port_0` stays 0 throughout.
